// File: rtl/t5_defs.sv
// Shared definitions for the t5 data-bus unit: fn3 size codes, mexc bit
// positions, FSM states and the lane-select / alignment helpers.
package t5_defs;

  localparam logic [1:0] FN3_B = 2'd0;
  localparam logic [1:0] FN3_H = 2'd1;
  localparam logic [1:0] FN3_W = 2'd2;
  localparam int FN3_UNS = 2;

  localparam int MEXC_MIS  = 0;
  localparam int MEXC_BERR = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Size code 3 has no encoding of its own and behaves as a word.
  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] adr_lo);
    case (size)
      FN3_B:   lane_sel = 4'b0001 << adr_lo;
      FN3_H:   lane_sel = adr_lo[1] ? 4'b1100 : 4'b0011;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] adr_lo);
    case (size)
      FN3_B:   misaligned = 1'b0;
      FN3_H:   misaligned = adr_lo[0];
      default: misaligned = |adr_lo;
    endcase
  endfunction

endpackage

// File: rtl/t5_ldext.sv
// Load extractor: picks the addressed byte/half out of a bus word and
// sign- or zero-extends it; word loads pass straight through.
module t5_ldext
  import t5_defs::*;
(
  input  logic [2:0]  fn3,
  input  logic [1:0]  adr_lo,
  input  logic [31:0] rdt,
  output logic [31:0] ldt
);

  logic [31:0] rdt_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sx;

  always_comb begin
    rdt_sh = rdt >> {adr_lo, 3'b000};
    byte_v = rdt_sh[7:0];
    half_v = adr_lo[1] ? rdt[31:16] : rdt[15:0];
    sx     = ~fn3[FN3_UNS];
    case (fn3[1:0])
      FN3_B:   ldt = {{24{sx & byte_v[7]}}, byte_v};
      FN3_H:   ldt = {{16{sx & half_v[15]}}, half_v};
      default: ldt = rdt;
    endcase
  end

endmodule

// File: rtl/t5_dbus.sv
// Data-bus load/store unit: accepts one execute-stage request, runs the
// stb/ack handshake with a timeout, and returns aligned load data or a trap flag.
module t5_dbus
  import t5_defs::*;
#(
  parameter int TOUT = 16
) (
  input  logic        sclk,
  input  logic        srst_n,
  input  logic        sena,
  input  logic        xld,
  input  logic        xst,
  input  logic [2:0]  xfn3,
  input  logic [31:0] xadr,
  input  logic [31:0] xdat,
  output logic [29:0] dwb_adr,
  output logic [31:0] dwb_dat,
  output logic [3:0]  dwb_sel,
  output logic        dwb_we,
  output logic        dwb_stb,
  input  logic        dwb_ack,
  input  logic [31:0] dwb_rdt,
  output logic        dstall,
  output logic [31:0] mldt,
  output logic        mlvd,
  output logic [1:0]  mexc
);

  localparam int CW = $clog2(TOUT + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    fn3_q;
  logic [1:0]    adr_lo_q;
  logic          ld_q;
  logic          req, mis, accept, tout_hit;
  logic [31:0]   ldt;

  assign req      = (xld | xst) & sena;
  assign mis      = misaligned(xfn3[1:0], xadr[1:0]);
  assign accept   = (state == IDLE) & req & ~mis;
  assign tout_hit = (cnt == CW'(TOUT - 1));

  t5_ldext u_ldext (
    .fn3    (fn3_q),
    .adr_lo (adr_lo_q),
    .rdt    (dwb_rdt),
    .ldt    (ldt)
  );

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // An ack on the final timeout cycle takes priority over the bus error.
  always_comb begin
    state_nxt = state;
    dstall    = 1'b0;
    mlvd      = 1'b0;
    case (state)
      IDLE: begin
        dstall = accept;
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        dstall = 1'b1;
        if (dwb_ack)       state_nxt = DONE;
        else if (tout_hit) state_nxt = IDLE;
      end
      DONE: begin
        mlvd      = ld_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      dwb_adr  <= '0;
      dwb_dat  <= '0;
      dwb_sel  <= '0;
      dwb_we   <= 1'b0;
      dwb_stb  <= 1'b0;
      fn3_q    <= '0;
      adr_lo_q <= '0;
      ld_q     <= 1'b0;
      cnt      <= '0;
      mldt     <= '0;
      mexc     <= '0;
    end else begin
      mexc <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            dwb_adr  <= xadr[31:2];
            dwb_dat  <= xdat;
            dwb_sel  <= lane_sel(xfn3[1:0], xadr[1:0]);
            dwb_we   <= xst;
            dwb_stb  <= 1'b1;
            fn3_q    <= xfn3;
            adr_lo_q <= xadr[1:0];
            ld_q     <= ~xst;
            cnt      <= '0;
          end else if (req) begin
            mexc[MEXC_MIS] <= 1'b1;
          end
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          if (dwb_ack) begin
            dwb_stb <= 1'b0;
            if (ld_q) mldt <= ldt;
          end else if (tout_hit) begin
            dwb_stb         <= 1'b0;
            mexc[MEXC_BERR] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
